// File: rtl/branch_resolve_unit.sv
// Dual-issue branch resolution: in-order prediction queue filled by fetch,
// drained by up to two Memory-stage resolves per cycle. Produces the
// registered predictor update port and a mispredict redirect/flush.
module branch_resolve_unit #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enq_valid1,
  input  logic            enq_valid2,
  input  logic [PC_W-1:0] enq_pc1,
  input  logic [PC_W-1:0] enq_pc2,
  input  logic            enq_pred_tk1,
  input  logic            enq_pred_tk2,
  input  logic [PC_W-1:0] enq_pred_tgt1,
  input  logic [PC_W-1:0] enq_pred_tgt2,
  output logic            enq_ready,
  input  logic            res_valid1,
  input  logic            res_valid2,
  input  logic            res_taken1,
  input  logic            res_taken2,
  input  logic [PC_W-1:0] res_target1,
  input  logic [PC_W-1:0] res_target2,
  output logic            branch1,
  output logic            branch2,
  output logic            branch_taken1,
  output logic            branch_taken2,
  output logic [PC_W-1:0] pcM1,
  output logic [PC_W-1:0] pcM2,
  output logic [PC_W-1:0] targetM1,
  output logic [PC_W-1:0] targetM2,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic [15:0]     br_count,
  output logic [15:0]     mispred_count,
  output logic            overflow_err,
  output logic            underflow_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PC_W-1:0] q_pc  [DEPTH];
  logic [PC_W-1:0] q_tgt [DEPTH];
  logic            q_tk  [DEPTH];
  logic [AW-1:0]   head, tail, head1, tail1;
  logic [CW-1:0]   count, n_enq, n_deq;
  logic            acc1, acc2, upd2, mp1, mp2, flush, uflow, do_enq, oflow;
  logic [PC_W-1:0] corr1, corr2;
  logic [16:0]     br_sum;

  assign enq_ready = (count <= CW'(DEPTH - 2));
  assign head1     = head + AW'(1);
  assign tail1     = tail + AW'(1);

  // Resolve acceptance, mispredict detection and enqueue gating
  always_comb begin
    acc1   = res_valid1 && (count != '0);
    acc2   = res_valid1 && res_valid2 && (count >= CW'(2));
    uflow  = (res_valid1 && (count == '0)) || (res_valid2 && !acc2);
    mp1    = acc1 && ((q_tk[head] != res_taken1) ||
                      (q_tk[head] && res_taken1 && (q_tgt[head] != res_target1)));
    // slot2 is wrong-path when slot1 mispredicts
    upd2   = acc2 && !mp1;
    mp2    = upd2 && ((q_tk[head1] != res_taken2) ||
                      (q_tk[head1] && res_taken2 && (q_tgt[head1] != res_target2)));
    flush  = mp1 || mp2;
    corr1  = res_taken1 ? res_target1 : q_pc[head] + PC_W'(1);
    corr2  = res_taken2 ? res_target2 : q_pc[head1] + PC_W'(1);
    n_deq  = CW'(acc1) + CW'(upd2);
    n_enq  = enq_valid1 ? (enq_valid2 ? CW'(2) : CW'(1)) : '0;
    // enqueues racing a flush are wrong-path, so they are not an overflow
    do_enq = enq_valid1 && enq_ready && !flush;
    oflow  = enq_valid1 && !enq_ready && !flush;
    br_sum = {1'b0, br_count} + 17'(n_deq);
  end

  // Entry storage; no reset needed, validity is tracked by head/count
  always_ff @(posedge clk) begin
    if (do_enq) begin
      q_pc[tail]  <= enq_pc1;
      q_tk[tail]  <= enq_pred_tk1;
      q_tgt[tail] <= enq_pred_tgt1;
      if (enq_valid2) begin
        q_pc[tail1]  <= enq_pc2;
        q_tk[tail1]  <= enq_pred_tk2;
        q_tgt[tail1] <= enq_pred_tgt2;
      end
    end
  end

  // Queue pointers, registered update/redirect outputs, counters and sticky errors
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      branch1        <= 1'b0;
      branch2        <= 1'b0;
      branch_taken1  <= 1'b0;
      branch_taken2  <= 1'b0;
      pcM1           <= '0;
      pcM2           <= '0;
      targetM1       <= '0;
      targetM2       <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      br_count       <= '0;
      mispred_count  <= '0;
      overflow_err   <= 1'b0;
      underflow_err  <= 1'b0;
    end else begin
      if (flush) begin
        head  <= tail;
        count <= '0;
      end else begin
        head  <= head + AW'(n_deq);
        if (do_enq) tail <= tail + AW'(n_enq);
        count <= count + (do_enq ? n_enq : '0) - n_deq;
      end
      branch1        <= acc1;
      branch_taken1  <= acc1 && res_taken1;
      pcM1           <= acc1 ? q_pc[head] : '0;
      targetM1       <= acc1 ? res_target1 : '0;
      branch2        <= upd2;
      branch_taken2  <= upd2 && res_taken2;
      pcM2           <= upd2 ? q_pc[head1] : '0;
      targetM2       <= upd2 ? res_target2 : '0;
      redirect_valid <= flush;
      redirect_pc    <= mp1 ? corr1 : (mp2 ? corr2 : '0);
      br_count       <= br_sum[16] ? 16'hFFFF : br_sum[15:0];
      if (flush && (mispred_count != 16'hFFFF)) mispred_count <= mispred_count + 16'd1;
      if (oflow) overflow_err  <= 1'b1;
      if (uflow) underflow_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model.
module tb_branch_resolve_unit;
  localparam int DEPTH = 8;
  localparam int PC_W  = 8;

  logic clk = 1'b0, reset = 1'b0;
  logic ev1, ev2, ptk1, ptk2, rv1, rv2, rt1, rt2;
  logic [7:0] epc1, epc2, ptg1, ptg2, rtg1, rtg2;
  logic enq_ready, branch1, branch2, branch_taken1, branch_taken2, redirect_valid;
  logic overflow_err, underflow_err;
  logic [7:0] pcM1, pcM2, targetM1, targetM2, redirect_pc;
  logic [15:0] br_count, mispred_count;

  branch_resolve_unit #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .reset(reset),
    .enq_valid1(ev1), .enq_valid2(ev2), .enq_pc1(epc1), .enq_pc2(epc2),
    .enq_pred_tk1(ptk1), .enq_pred_tk2(ptk2), .enq_pred_tgt1(ptg1), .enq_pred_tgt2(ptg2),
    .enq_ready(enq_ready),
    .res_valid1(rv1), .res_valid2(rv2), .res_taken1(rt1), .res_taken2(rt2),
    .res_target1(rtg1), .res_target2(rtg2),
    .branch1(branch1), .branch2(branch2), .branch_taken1(branch_taken1),
    .branch_taken2(branch_taken2), .pcM1(pcM1), .pcM2(pcM2),
    .targetM1(targetM1), .targetM2(targetM2),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .br_count(br_count), .mispred_count(mispred_count),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] pc; logic tk; logic [7:0] tgt; } ent_t;
  ent_t q[$];

  logic       e_b1, e_b2, e_bt1, e_bt2, e_rv, e_oerr, e_uerr;
  logic [7:0] e_pc1, e_pc2, e_tg1, e_tg2, e_rpc;
  int         e_br, e_mp;
  int         checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic mispred(input ent_t e, input logic tk, input logic [7:0] tgt);
    return (e.tk != tk) || (e.tk && tk && e.tgt != tgt);
  endfunction

  // Reference: compute next-cycle outputs and new queue contents from current inputs.
  task automatic model();
    int n = q.size();
    int nacc = 0;
    logic fl = 1'b0;
    e_b1 = 0; e_b2 = 0; e_bt1 = 0; e_bt2 = 0; e_pc1 = 0; e_pc2 = 0;
    e_tg1 = 0; e_tg2 = 0; e_rv = 0; e_rpc = 0;
    if (rv1 && n >= 1) begin
      e_b1 = 1; e_bt1 = rt1; e_pc1 = q[0].pc; e_tg1 = rtg1; nacc = 1;
      if (mispred(q[0], rt1, rtg1)) begin
        fl = 1; e_rpc = rt1 ? rtg1 : 8'(q[0].pc + 8'd1);
      end else if (rv2 && n >= 2) begin
        e_b2 = 1; e_bt2 = rt2; e_pc2 = q[1].pc; e_tg2 = rtg2; nacc = 2;
        if (mispred(q[1], rt2, rtg2)) begin
          fl = 1; e_rpc = rt2 ? rtg2 : 8'(q[1].pc + 8'd1);
        end
      end
    end
    if ((rv1 && n == 0) || (rv2 && !(rv1 && n >= 2))) e_uerr = 1;
    e_rv = fl;
    if (fl) q.delete();
    else begin
      repeat (nacc) void'(q.pop_front());
      if (ev1) begin
        if (n <= DEPTH - 2) begin
          q.push_back('{epc1, ptk1, ptg1});
          if (ev2) q.push_back('{epc2, ptk2, ptg2});
        end else e_oerr = 1;
      end
    end
    e_br = (e_br + nacc > 65535) ? 65535 : e_br + nacc;
    if (fl && e_mp < 65535) e_mp++;
  endtask

  task automatic chk_all();
    chk("branch1", branch1, e_b1);           chk("branch2", branch2, e_b2);
    chk("branch_taken1", branch_taken1, e_bt1); chk("branch_taken2", branch_taken2, e_bt2);
    chk("pcM1", pcM1, e_pc1);                chk("pcM2", pcM2, e_pc2);
    chk("targetM1", targetM1, e_tg1);        chk("targetM2", targetM2, e_tg2);
    chk("redirect_valid", redirect_valid, e_rv);
    chk("redirect_pc", redirect_pc, e_rpc);
    chk("br_count", br_count, e_br);         chk("mispred_count", mispred_count, e_mp);
    chk("overflow_err", overflow_err, e_oerr);
    chk("underflow_err", underflow_err, e_uerr);
  endtask

  // Inputs are applied at negedge; outputs checked at the following negedge.
  task automatic step();
    chk("enq_ready", enq_ready, q.size() <= DEPTH - 2);
    model();
    @(posedge clk); @(negedge clk);
    chk_all();
  endtask

  task automatic idle();
    ev1 = 0; ev2 = 0; epc1 = 0; epc2 = 0; ptk1 = 0; ptk2 = 0; ptg1 = 0; ptg2 = 0;
    rv1 = 0; rv2 = 0; rt1 = 0; rt2 = 0; rtg1 = 0; rtg2 = 0;
  endtask

  task automatic set_enq(input logic v1, input logic [7:0] p1, input logic t1, input logic [7:0] g1,
                         input logic v2, input logic [7:0] p2, input logic t2, input logic [7:0] g2);
    ev1 = v1; epc1 = p1; ptk1 = t1; ptg1 = g1; ev2 = v2; epc2 = p2; ptk2 = t2; ptg2 = g2;
  endtask

  task automatic set_res(input logic v1, input logic t1, input logic [7:0] g1,
                         input logic v2, input logic t2, input logic [7:0] g2);
    rv1 = v1; rt1 = t1; rtg1 = g1; rv2 = v2; rt2 = t2; rtg2 = g2;
  endtask

  task automatic do_reset();
    idle(); reset = 0;
    @(posedge clk); @(negedge clk);
    q.delete();
    e_b1 = 0; e_b2 = 0; e_bt1 = 0; e_bt2 = 0; e_pc1 = 0; e_pc2 = 0; e_tg1 = 0; e_tg2 = 0;
    e_rv = 0; e_rpc = 0; e_br = 0; e_mp = 0; e_oerr = 0; e_uerr = 0;
    chk_all();
    reset = 1;
    #1 chk("rst enq_ready", enq_ready, 1);
  endtask

  initial begin
    idle();
    @(negedge clk);
    do_reset();

    // 1) reset mid-stream with 3 queued entries
    set_enq(1, 8'h01, 0, 0, 1, 8'h02, 0, 0); step();
    set_enq(1, 8'h03, 0, 0, 0, 0, 0, 0);     step();
    idle(); step();
    do_reset();
    chk("t1 br_count", br_count, 0);
    // an empty queue must flag a resolve as underflow
    set_res(1, 0, 0, 0, 0, 0); step();
    chk("t1 empty underflow", underflow_err, 1);
    do_reset();

    // 2) correct not-taken prediction
    set_enq(1, 8'h10, 0, 8'h00, 0, 0, 0, 0); step();
    idle(); set_res(1, 0, 8'h00, 0, 0, 0); step();
    chk("t2 branch1", branch1, 1); chk("t2 taken1", branch_taken1, 0);
    chk("t2 pcM1", pcM1, 8'h10);  chk("t2 redirect", redirect_valid, 0);
    chk("t2 br_count", br_count, 1);

    // 3) direction mispredict, taken to 0x40
    idle(); set_enq(1, 8'h20, 0, 8'h00, 0, 0, 0, 0); step();
    idle(); set_res(1, 1, 8'h40, 0, 0, 0); step();
    chk("t3 redirect", redirect_valid, 1); chk("t3 redirect_pc", redirect_pc, 8'h40);
    chk("t3 mispred", mispred_count, 1);   chk("t3 qsize", q.size(), 0);

    // 4) dual resolve, slot1 mispredicts, slot2 wrong-path
    idle(); set_enq(1, 8'h30, 1, 8'h50, 1, 8'h31, 0, 8'h00); step();
    idle(); set_res(1, 0, 8'h50, 1, 0, 8'h00); step();
    chk("t4 redirect_pc", redirect_pc, 8'h31); chk("t4 branch1", branch1, 1);
    chk("t4 branch2", branch2, 0);             chk("t4 br_count", br_count, 3);

    // 5) target mispredict
    idle(); set_enq(1, 8'h60, 1, 8'h70, 0, 0, 0, 0); step();
    idle(); set_res(1, 1, 8'h72, 0, 0, 0); step();
    chk("t5 redirect", redirect_valid, 1); chk("t5 redirect_pc", redirect_pc, 8'h72);
    chk("t5 targetM1", targetM1, 8'h72);

    // 6) fill, overflow, then 3 wraps of FIFO traffic
    for (int i = 0; i < 4; i++) begin
      idle(); set_enq(1, 8'(8'h80 + 2*i), 0, 0, 1, 8'(8'h81 + 2*i), 0, 0); step();
    end
    idle(); #1 chk("t6 full enq_ready", enq_ready, 0);
    set_enq(1, 8'hEE, 0, 0, 1, 8'hEF, 0, 0); step();
    chk("t6 overflow", overflow_err, 1);
    for (int i = 0; i < 12; i++) begin
      idle(); set_res(1, 0, 0, 1, 0, 0); step();
      chk("t6 fifo pc1", pcM1, 8'(8'h80 + 2*i));
      chk("t6 fifo pc2", pcM2, 8'(8'h81 + 2*i));
      idle(); set_enq(1, 8'(8'h88 + 2*i), 0, 0, 1, 8'(8'h89 + 2*i), 0, 0); step();
    end

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      idle();
      ev1 = ($urandom_range(2) != 0); ev2 = $urandom_range(1);
      epc1 = 8'($urandom); epc2 = 8'($urandom);
      ptk1 = $urandom_range(1); ptk2 = $urandom_range(1);
      ptg1 = 8'($urandom); ptg2 = 8'($urandom);
      rv1 = ($urandom_range(4) < 3) && (q.size() > 0 || $urandom_range(30) == 0);
      rv2 = rv1 ? ($urandom_range(1) == 1) : ($urandom_range(40) == 0);
      rt1 = $urandom_range(1); rt2 = $urandom_range(1);
      rtg1 = 8'($urandom); rtg2 = 8'($urandom);
      if (q.size() > 0 && $urandom_range(9) < 8) begin rt1 = q[0].tk; rtg1 = q[0].tgt; end
      if (q.size() > 1 && $urandom_range(9) < 8) begin rt2 = q[1].tk; rtg2 = q[1].tgt; end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
